// File: rtl/rr_dispatcher.sv
// Pops one upstream FIFO and pushes each word into one of four channel FIFOs, chosen by dest field or round-robin.
// A word is pushed 1 cycle after its in_valid at the earliest; a full target stalls everything and pops stop when the 2-entry skid buffer would overflow.
module rr_dispatcher #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_pop,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 rr_mode,
    input  logic [3:0]           out_full,
    output logic [3:0]           out_push,
    output logic [DATA_W-1:0]    out_data,
    output logic [4*CNT_W-1:0]   push_count,
    output logic                 idle,
    output logic                 err
);

    logic [DATA_W-1:0] skid_q [2];
    logic              head;
    logic              tail;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              pop_inflight;
    logic [1:0]        rr_ptr;
    logic              rel_guard;
    logic [CNT_W-1:0]  cnt [4];

    logic [DATA_W-1:0] head_dat;
    logic [1:0]        tgt;
    logic              drain;
    logic [2:0]        lvl;
    logic              valid_ok;
    logic              stray;
    logic              ovf;
    logic              wr;

    always_comb begin
        head_dat = skid_q[head];
        tgt      = rr_mode ? rr_ptr : head_dat[DATA_W-1 -: 2];
        drain    = (occ != 2'd0) && !out_full[tgt];
        out_push = drain ? (4'b0001 << tgt) : 4'b0000;
        out_data = head_dat;
        // Space check counts the word already requested but not yet returned.
        lvl      = {1'b0, occ} + {2'b00, pop_inflight} - {2'b00, drain};
        in_pop   = !reset && !in_empty && (lvl < 3'd2);
        // The first cycle after reset release may still see a pre-reset read response.
        valid_ok = in_valid && !rel_guard;
        stray    = valid_ok && !pop_inflight;
        ovf      = valid_ok && pop_inflight && (occ == 2'd2) && !drain;
        wr       = valid_ok && pop_inflight && !ovf;
        occ_nxt  = occ + {1'b0, wr} - {1'b0, drain};
        idle     = (occ == 2'd0) && !pop_inflight && in_empty;
    end

    always_comb begin
        push_count = '0;
        for (int i = 0; i < 4; i++) begin
            push_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
            head         <= 1'b0;
            tail         <= 1'b0;
            occ          <= 2'd0;
            pop_inflight <= 1'b0;
            rr_ptr       <= 2'd0;
            rel_guard    <= 1'b1;
            err          <= 1'b0;
        end else begin
            rel_guard    <= 1'b0;
            pop_inflight <= in_pop;
            occ          <= occ_nxt;
            err          <= err | stray | ovf;
            if (wr) begin
                skid_q[tail] <= in_data;
                tail         <= ~tail;
            end
            if (drain) begin
                head <= ~head;
                if (rr_mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_push[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
